// File: rtl/bram_row_fetcher.sv
// bram_row_fetcher: fetches MATRIX_SIZE rows per command from the operand BRAMs into a per-lane FIFO and streams them to the decoder
// Optional ZERO_PAD_EN: appends MATRIX_SIZE-1 all-zero rows after the data rows to flush the skewed array.
module bram_row_fetcher #(
   parameter int REG_WIDTH    = 16,
   parameter int MATRIX_SIZE  = 4,
   parameter int BRAM_DEPTH   = MATRIX_SIZE * REG_WIDTH,
   parameter int VECTOR       = 2,
   parameter int ADDR_WIDTH   = 8,
   parameter int BRAM_LATENCY = 2,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   output logic                  busy,
   output logic                  done,
   output logic                  bram_en,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   input  logic [BRAM_DEPTH-1:0] bram_dout [VECTOR],
   input  logic                  dec_ready,
   output logic [BRAM_DEPTH-1:0] data_bram [VECTOR],
   output logic                  enable
);
`ifdef ZERO_PAD_EN
   localparam int TOTAL = 2 * MATRIX_SIZE - 1;
`else
   localparam int TOTAL = MATRIX_SIZE;
`endif
   localparam int IW = $clog2(MATRIX_SIZE + 1);
   localparam int OW = $clog2(TOTAL + 1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + BRAM_LATENCY + 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   base_q, base_d;
   logic [IW-1:0]           issued_q, issued_d;
   logic [OW-1:0]           popped_q, popped_d;
   logic [BRAM_LATENCY-1:0] vld_q, vld_d;
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]           count_q, count_d;
   logic                    done_q, done_d;
   logic [BRAM_DEPTH-1:0]   mem_q [FIFO_DEPTH][VECTOR];
   logic [BRAM_DEPTH-1:0]   mem_d [FIFO_DEPTH][VECTOR];
   logic [CW-1:0]           in_flight;
   logic                    pad, push, pop, last_pop, accept;

`ifdef ZERO_PAD_EN
   assign pad = (state_q == DRAIN) && (popped_q >= OW'(MATRIX_SIZE));
`else
   assign pad = 1'b0;
`endif

   // reads issued but not yet captured: population count of the valid pipeline
   always_comb begin
      in_flight = '0;
      for (int i = 0; i < BRAM_LATENCY; i++) in_flight = in_flight + CW'(vld_q[i]);
   end

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    state_d = start ? FETCH : IDLE;
         FETCH:   state_d = (issued_q == IW'(MATRIX_SIZE)) ? DRAIN : FETCH;
         DRAIN:   state_d = last_pop ? IDLE : DRAIN;
         default: state_d = IDLE;
      endcase
   end

   // outputs: credit-gated read issue, FIFO head (or zero pad row) to the decoder
   always_comb begin
      accept    = (state_q == IDLE) && start;
      busy      = state_q != IDLE;
      done      = done_q;
      bram_en   = (state_q == FETCH) && (issued_q < IW'(MATRIX_SIZE)) && ((count_q + in_flight) < CW'(FIFO_DEPTH));
      bram_addr = base_q + ADDR_WIDTH'(issued_q);
      enable    = dec_ready && ((count_q != '0) || pad);
      push      = vld_q[BRAM_LATENCY-1];
      pop       = enable && !pad;
      last_pop  = (state_q == DRAIN) && enable && (popped_q == OW'(TOTAL - 1));
      for (int v = 0; v < VECTOR; v++) data_bram[v] = pad ? '0 : mem_q[rd_ptr_q][v];
   end

   // datapath next values: counters, read-valid pipeline, FIFO pointers and storage
   always_comb begin
      base_d   = accept ? base_addr : base_q;
      issued_d = accept ? '0 : issued_q + IW'(bram_en);
      popped_d = accept ? '0 : popped_q + OW'(enable);
      vld_d    = (vld_q << 1) | BRAM_LATENCY'(bram_en);
      count_d  = count_q + CW'(push) - CW'(pop);
      wr_ptr_d = push ? ((wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1)) : wr_ptr_q;
      rd_ptr_d = pop ? ((rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1)) : rd_ptr_q;
      done_d   = last_pop;
      mem_d    = mem_q;
      if (push) for (int v = 0; v < VECTOR; v++) mem_d[wr_ptr_q][v] = bram_dout[v];
   end

   // datapath registers; reset drops any in-flight reads and buffered rows
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         base_q   <= '0;
         issued_q <= '0;
         popped_q <= '0;
         vld_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         done_q   <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++)
            for (int v = 0; v < VECTOR; v++) mem_q[i][v] <= '0;
      end else begin
         base_q   <= base_d;
         issued_q <= issued_d;
         popped_q <= popped_d;
         vld_q    <= vld_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         done_q   <= done_d;
         mem_q    <= mem_d;
      end
   end
endmodule

// File: tb/tb_bram_row_fetcher.sv
// tb_bram_row_fetcher: scoreboard bench for bram_row_fetcher (honours ZERO_PAD_EN)
module tb_bram_row_fetcher;
   localparam int RW = 16, MS = 4, BD = MS * RW, V = 2, AW = 8, L = 2, FD = 4;
`ifdef ZERO_PAD_EN
   localparam int TOTAL = 2 * MS - 1;
`else
   localparam int TOTAL = MS;
`endif

   logic          clk = 1'b0, reset_n = 1'b0, start = 1'b0, dec_ready = 1'b1;
   logic [AW-1:0] base_addr = '0, base_cur = '0, bram_addr;
   logic          busy, done, bram_en, enable;
   logic [BD-1:0] bram_dout [V];
   logic [BD-1:0] data_bram [V];
   logic [V*BD-1:0] pipe [L];
   logic [V*BD-1:0] exp_rows [$];
   logic [AW-1:0]   exp_addr [$];
   logic [V*BD-1:0] mon_act, mon_exp;
   logic [AW-1:0]   mon_addr;
   int n_chk = 0, n_pass = 0;
   int en_cnt = 0, rd_cnt = 0, done_cnt = 0;

   always #5 clk = ~clk;

   bram_row_fetcher #(.REG_WIDTH(RW), .MATRIX_SIZE(MS), .BRAM_DEPTH(BD), .VECTOR(V),
                      .ADDR_WIDTH(AW), .BRAM_LATENCY(L), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .busy(busy),
      .done(done), .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
      .dec_ready(dec_ready), .data_bram(data_bram), .enable(enable));

   // row k of a command: every element of lane v holds k + 256*v
   function automatic logic [V*BD-1:0] row_of(input int k);
      logic [V*BD-1:0] r;
      for (int v = 0; v < V; v++)
         for (int e = 0; e < MS; e++) r[v*BD + e*RW +: RW] = RW'(k) + RW'(v * 256);
      return r;
   endfunction

   task automatic check(input string name, input logic ok, input logic [V*BD-1:0] act, input logic [V*BD-1:0] exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // BRAM model: row number relative to the command base, L-cycle read latency
   always @(posedge clk) begin
      pipe[0] <= bram_en ? row_of(int'(AW'(bram_addr - base_cur)) + 1) : '0;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
   end
   always_comb for (int v = 0; v < V; v++) bram_dout[v] = pipe[L-1][v*BD +: BD];

   // monitor: compare every read address and every transferred row against the scoreboard
   always @(negedge clk) begin
      if (reset_n) begin
         if (bram_en) begin
            rd_cnt++;
            if (exp_addr.size() == 0) check("extra_read", 1'b0, bram_addr, '0);
            else begin
               mon_addr = exp_addr.pop_front();
               check("bram_addr", bram_addr == mon_addr, bram_addr, mon_addr);
            end
         end
         if (enable) begin
            en_cnt++;
            for (int v = 0; v < V; v++) mon_act[v*BD +: BD] = data_bram[v];
            if (exp_rows.size() == 0) check("extra_row", 1'b0, mon_act, '0);
            else begin
               mon_exp = exp_rows.pop_front();
               check("data_bram", mon_act == mon_exp, mon_act, mon_exp);
            end
         end
         if (done) done_cnt++;
      end
   end

   task automatic issue(input logic [AW-1:0] b);
      for (int k = 0; k < MS; k++) exp_addr.push_back(b + AW'(k));
      for (int k = 1; k <= MS; k++) exp_rows.push_back(row_of(k));
      for (int k = MS; k < TOTAL; k++) exp_rows.push_back('0);
      base_addr = b;
      base_cur = b;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int i;
      for (i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done) break;
      end
      check(name, done, done, 1'b1);
   endtask

   initial begin
      logic [11:0] en_h, ev_h, dn_h, bz_h;
      logic [V*BD-1:0] head;
      int e0, r0, d0;
      bit ok;
      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_outputs", {busy, done, bram_en, enable, bram_addr} == '0, {busy, done, bram_en, enable, bram_addr}, '0);
      reset_n = 1'b1;

      // 1: reset mid-FETCH with two rows buffered
      dec_ready = 1'b0;
      issue(8'h30);
      repeat (4) @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      check("abort_busy", busy == 1'b0, busy, 1'b0);
      check("abort_ctrl", {done, bram_en, enable} == 3'b000, {done, bram_en, enable}, 3'b000);
      check("abort_addr", bram_addr == '0, bram_addr, '0);
      check("abort_data", {data_bram[1], data_bram[0]} == '0, {data_bram[1], data_bram[0]}, '0);
      exp_addr.delete();
      exp_rows.delete();
      d0 = done_cnt;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      dec_ready = 1'b1;
      check("abort_no_done", done_cnt == d0, done_cnt, d0);
      issue(8'h10);
      wait_done("t1_done");
      check("t1_drained", exp_rows.size() + exp_addr.size() == 0, exp_rows.size() + exp_addr.size(), 0);

      // 2: cycle-exact timing, start sampled at edge 0
      @(posedge clk);
      #1;
      issue(8'h20);
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         en_h[n] = bram_en;
         ev_h[n] = enable;
         dn_h[n] = done;
         bz_h[n] = busy;
      end
      check("t2_read_edges", en_h == 12'h00f, en_h, 12'h00f);
      check("t2_enable_edges", ev_h == 12'(((1 << TOTAL) - 1) << 3), ev_h, 12'(((1 << TOTAL) - 1) << 3));
      check("t2_done_cycle", dn_h == 12'(1 << (3 + TOTAL)), dn_h, 12'(1 << (3 + TOTAL)));
      check("t2_busy_in_done", bz_h[3 + TOTAL] == 1'b0, bz_h[3 + TOTAL], 1'b0);

      // 3: backpressure holds the head row and caps outstanding reads
      dec_ready = 1'b0;
      @(posedge clk);
      #1;
      e0 = en_cnt;
      r0 = rd_cnt;
      issue(8'h50);
      for (int n = 0; n < 6; n++) @(negedge clk);
      for (int v = 0; v < V; v++) head[v*BD +: BD] = data_bram[v];
      check("t3_reads_capped", rd_cnt - r0 <= FD, rd_cnt - r0, FD);
      check("t3_no_enable", en_cnt == e0, en_cnt - e0, 0);
      check("t3_head_held", head == row_of(1), head, row_of(1));
      dec_ready = 1'b1;
      wait_done("t3_done");
      check("t3_row_count", en_cnt - e0 == TOTAL, en_cnt - e0, TOTAL);
      check("t3_read_count", rd_cnt - r0 == MS, rd_cnt - r0, MS);
      check("t3_drained", exp_rows.size() == 0, exp_rows.size(), 0);

      // 4: address wrap 0xFE..0x01
      @(posedge clk);
      #1;
      issue(8'hfe);
      wait_done("t4_done");
      check("t4_drained", exp_addr.size() + exp_rows.size() == 0, exp_addr.size() + exp_rows.size(), 0);

      // 5: start while busy ignored; start in the done cycle accepted
      @(posedge clk);
      #1;
      r0 = rd_cnt;
      issue(8'h60);
      @(posedge clk);
      #1 base_addr = 8'h99;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done("t5a_done");
      check("t5_ignored_start", rd_cnt - r0 == MS, rd_cnt - r0, MS);
      issue(8'h40);
      @(negedge clk);
      check("t5_b2b_read", bram_en && bram_addr == 8'h40, {bram_en, bram_addr}, {1'b1, 8'h40});
      wait_done("t5b_done");
      ok = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (busy || bram_en || enable) ok = 1'b0;
      end
      check("t5_idle_after", ok, {busy, bram_en, enable}, '0);
      check("t5_drained", exp_addr.size() + exp_rows.size() == 0, exp_addr.size() + exp_rows.size(), 0);

      // 6: base 0x00, row and read counts per build
      @(posedge clk);
      #1;
      e0 = en_cnt;
      r0 = rd_cnt;
      issue(8'h00);
      wait_done("t6_done");
      check("t6_enable_count", en_cnt - e0 == TOTAL, en_cnt - e0, TOTAL);
      check("t6_read_count", rd_cnt - r0 == MS, rd_cnt - r0, MS);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end
endmodule
